// File: rtl/int_alu_pipe.sv
// Lane-chunked warp integer ALU: LANES lanes per beat, iterative restoring signed
// divide/remainder, per-lane masking, full-warp result held until writeback accepts it.
module int_alu_pipe #(
  parameter int unsigned WARP_SIZE = 32,
  parameter int unsigned LANES     = 8,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_op,
  input  logic [4:0]              in_warp,
  input  logic [31:0]             in_imm,
  input  logic [WARP_SIZE*32-1:0] in_rs1,
  input  logic [WARP_SIZE*32-1:0] in_rs2,
  input  logic [WARP_SIZE*32-1:0] in_rs3,
  input  logic [WARP_SIZE-1:0]    in_pred,
  input  logic [WARP_SIZE-1:0]    in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              out_warp,
  output logic [WARP_SIZE*32-1:0] out_result,
  output logic                    out_illegal
);

  localparam int unsigned BEATS = WARP_SIZE / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IW    = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam int unsigned LW    = (WARP_SIZE > 1) ? $clog2(WARP_SIZE) : 1;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h00, OP_SUB  = 8'h01, OP_MUL  = 8'h02, OP_IMAD = 8'h03,
    OP_AND  = 8'h04, OP_OR   = 8'h05, OP_XOR  = 8'h06, OP_SHL  = 8'h07,
    OP_SHR  = 8'h08, OP_SHA  = 8'h09, OP_SLT  = 8'h0A, OP_SEQ  = 8'h0B,
    OP_SLE  = 8'h0C, OP_IMIN = 8'h0D, OP_IMAX = 8'h0E, OP_MOV  = 8'h0F,
    OP_SELP = 8'h10, OP_TID  = 8'h11, OP_IDIV = 8'h12, OP_IREM = 8'h13
  } opcode_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_DONE} state_e;

  state_e                  state;
  logic [7:0]              op_q;
  logic [31:0]             imm_q;
  logic [WARP_SIZE*32-1:0] rs1_q, rs2_q, rs3_q;
  logic [WARP_SIZE-1:0]    pred_q, mask_q;
  logic [CW-1:0]           chunk;
  logic [IW-1:0]           iter;
  logic [31:0]             rem_q [LANES];
  logic [31:0]             dvd_q [LANES];

  logic [LW-1:0] lane_base;
  logic [LW-1:0] lane_of  [LANES];
  logic [31:0]   exec_val [LANES];
  logic [31:0]   div_val  [LANES];
  logic [31:0]   rem_nx   [LANES];
  logic [31:0]   dvd_nx   [LANES];
  logic          chunk_active, last_chunk, last_iter, div_start;

  function automatic logic op_legal(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_IMAD, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
      OP_SHA, OP_SLT, OP_SEQ, OP_SLE, OP_IMIN, OP_IMAX, OP_MOV, OP_SELP,
      OP_TID, OP_IDIV, OP_IREM: op_legal = 1'b1;
      default:                  op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [7:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] c,
                                      input logic [31:0] imm, input logic p,
                                      input logic [31:0] lane);
    logic [31:0] bs, bl, r;
    bs = b + imm;
    bl = b | imm;
    r  = '0;
    case (op)
      OP_ADD:  r = a + bs;
      OP_SUB:  r = a - b - imm;
      OP_MUL:  r = a * bs;
      OP_IMAD: r = a * b + c;
      OP_AND:  r = a & bl;
      OP_OR:   r = a | bl;
      OP_XOR:  r = a ^ bl;
      OP_SHL:  r = (bs > 32'd31) ? '0 : a << bs[4:0];
      OP_SHR:  r = (bs > 32'd31) ? '0 : a >> bs[4:0];
      OP_SHA:  r = (bs > 32'd31) ? {32{a[31]}} : 32'($signed(a) >>> bs[4:0]);
      OP_SLT:  r = {31'd0, a < bs};
      OP_SEQ:  r = {31'd0, a == bs};
      OP_SLE:  r = {31'd0, $signed(a) <= $signed(bs)};
      OP_IMIN: r = ($signed(a) < $signed(bs)) ? a : bs;
      OP_IMAX: r = ($signed(a) > $signed(bs)) ? a : bs;
      OP_MOV:  r = a | imm;
      OP_SELP: r = p ? a : b;
      OP_TID:  r = lane;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    logic [31:0] a, b, bsum, abs_a, abs_b, cur_rem, cur_dvd, quo, rem;
    logic [32:0] part;
    logic        ge, active;
    lane_base    = LW'(32'(chunk) * LANES);
    chunk_active = |mask_q[lane_base +: LANES];
    last_chunk   = (32'(chunk) == BEATS - 1);
    last_iter    = (32'(iter) == DIV_ITERS - 1);
    div_start    = (iter == '0);
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_of[j] = lane_base + LW'(j);
      a      = rs1_q[{lane_of[j], 5'd0} +: 32];
      b      = rs2_q[{lane_of[j], 5'd0} +: 32];
      bsum   = b + imm_q;
      active = mask_q[lane_of[j]];
      exec_val[j] = active ? alu(op_q, a, b, rs3_q[{lane_of[j], 5'd0} +: 32], imm_q,
                                 pred_q[lane_of[j]], 32'(lane_of[j])) : '0;
      // One restoring step on magnitudes; first step of a chunk seeds from the operands.
      abs_a   = a[31] ? -a : a;
      abs_b   = bsum[31] ? -bsum : bsum;
      cur_rem = div_start ? '0 : rem_q[j];
      cur_dvd = div_start ? abs_a : dvd_q[j];
      part    = {cur_rem, cur_dvd[31]};
      ge      = (part >= {1'b0, abs_b});
      rem_nx[j] = ge ? 32'(part - {1'b0, abs_b}) : part[31:0];
      dvd_nx[j] = {cur_dvd[30:0], ge};
      quo = (a[31] ^ bsum[31]) ? -dvd_nx[j] : dvd_nx[j];
      rem = a[31] ? -rem_nx[j] : rem_nx[j];
      if (bsum == '0) begin
        quo = '1;
        rem = a;
      end
      div_val[j] = !active ? '0 : (op_q == OP_IREM) ? rem : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_warp    <= '0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      chunk       <= '0;
      iter        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready    <= 1'b0;
            out_warp    <= in_warp;
            out_result  <= '0;
            out_illegal <= !op_legal(in_op);
            chunk       <= '0;
            iter        <= '0;
            state       <= (in_op == OP_IDIV || in_op == OP_IREM) ? S_DIV : S_EXEC;
          end
        end
        S_EXEC: begin
          for (int unsigned j = 0; j < LANES; j++)
            out_result[{lane_of[j], 5'd0} +: 32] <= exec_val[j];
          if (last_chunk) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            chunk <= chunk + CW'(1);
          end
        end
        S_DIV: begin
          // A fully masked chunk leaves its zeroed lanes untouched and moves on.
          if ((div_start && !chunk_active) || last_iter) begin
            if (last_iter) begin
              for (int unsigned j = 0; j < LANES; j++)
                out_result[{lane_of[j], 5'd0} +: 32] <= div_val[j];
            end
            iter <= '0;
            if (last_chunk) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              chunk <= chunk + CW'(1);
            end
          end else begin
            iter <= iter + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      op_q   <= in_op;
      imm_q  <= in_imm;
      rs1_q  <= in_rs1;
      rs2_q  <= in_rs2;
      rs3_q  <= in_rs3;
      pred_q <= in_pred;
      mask_q <= in_mask;
    end
    if (state == S_DIV) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        rem_q[j] <= rem_nx[j];
        dvd_q[j] <= dvd_nx[j];
      end
    end
  end

endmodule

// File: tb/tb_int_alu_pipe.sv
// Self-checking bench for int_alu_pipe: lane-level behavioural model, queue-based
// output compare on every valid cycle, plus directed literal expectations.
module tb_int_alu_pipe;
  localparam int WS    = 32;
  localparam int LN    = 8;
  localparam int BEATS = WS / LN;

  localparam logic [7:0] ADD  = 8'h00, SUB  = 8'h01, MUL  = 8'h02, IMAD = 8'h03,
                         AND_ = 8'h04, OR_  = 8'h05, XOR_ = 8'h06, SHL  = 8'h07,
                         SHR  = 8'h08, SHA  = 8'h09, SLT  = 8'h0A, SEQ  = 8'h0B,
                         SLE  = 8'h0C, IMIN = 8'h0D, IMAX = 8'h0E, MOV  = 8'h0F,
                         SELP = 8'h10, TID  = 8'h11, IDIV = 8'h12, IREM = 8'h13;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_illegal;
  logic [7:0]       in_op = 8'h00;
  logic [4:0]       in_warp = '0, out_warp;
  logic [31:0]      in_imm = '0;
  logic [WS*32-1:0] in_rs1, in_rs2, in_rs3, out_result;
  logic [WS-1:0]    in_pred = '0, in_mask = '1;
  logic [31:0]      s_rs1 [WS], s_rs2 [WS], s_rs3 [WS];

  int n_err = 0, n_checks = 0, cyc = 0, acc_cyc = 0;

  typedef struct {
    logic [WS*32-1:0] res;
    logic [4:0]       warp;
    logic             ill;
  } exp_t;
  exp_t exp_q [$];

  int_alu_pipe #(.WARP_SIZE(WS), .LANES(LN), .DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_warp(in_warp), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs3(in_rs3), .in_pred(in_pred), .in_mask(in_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_warp(out_warp), .out_result(out_result),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int l = 0; l < WS; l++) begin
      in_rs1[l*32 +: 32] = s_rs1[l];
      in_rs2[l*32 +: 32] = s_rs2[l];
      in_rs3[l*32 +: 32] = s_rs3[l];
    end
  end

  function automatic bit known(input logic [7:0] op);
    return op <= IREM;
  endfunction

  function automatic logic [31:0] model_lane(input int l);
    logic [31:0] a, b, c, bs;
    longint sa, sb;
    a = s_rs1[l]; b = s_rs2[l]; c = s_rs3[l]; bs = b + in_imm;
    if (!in_mask[l] || !known(in_op)) return 32'd0;
    case (in_op)
      ADD:  return a + b + in_imm;
      SUB:  return a - b - in_imm;
      MUL:  return a * bs;
      IMAD: return a * b + c;
      AND_: return a & (b | in_imm);
      OR_:  return a | (b | in_imm);
      XOR_: return a ^ (b | in_imm);
      SHL:  return a << bs;
      SHR:  return a >> bs;
      SHA:  return $signed(a) >>> bs;
      SLT:  return (a < bs) ? 32'd1 : 32'd0;
      SEQ:  return (a == bs) ? 32'd1 : 32'd0;
      SLE:  return ($signed(a) <= $signed(bs)) ? 32'd1 : 32'd0;
      IMIN: return ($signed(a) < $signed(bs)) ? a : bs;
      IMAX: return ($signed(a) > $signed(bs)) ? a : bs;
      MOV:  return a | in_imm;
      SELP: return in_pred[l] ? a : b;
      TID:  return 32'(l);
      default: begin
        sa = longint'($signed(a));
        sb = longint'($signed(bs));
        if (sb == 0) return (in_op == IDIV) ? 32'hFFFF_FFFF : a;
        return (in_op == IDIV) ? 32'(sa / sb) : 32'(sa % sb);
      end
    endcase
  endfunction

  function automatic exp_t model();
    exp_t e;
    for (int l = 0; l < WS; l++) e.res[l*32 +: 32] = model_lane(l);
    e.warp = in_warp;
    e.ill  = !known(in_op);
    return e;
  endfunction

  function automatic int exp_latency();
    int lat;
    if (in_op != IDIV && in_op != IREM) return BEATS + 1;
    lat = 1;
    for (int c = 0; c < BEATS; c++) lat += (|in_mask[c*LN +: LN]) ? 32 : 1;
    return lat;
  endfunction

  function automatic logic [31:0] lane(input int l);
    return out_result[l*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare the held output against the model on every cycle it is valid.
  always @(negedge clk) begin
    int bad;
    bad = -1;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_out: out_valid=1 with no instruction outstanding");
      end else begin
        for (int l = WS - 1; l >= 0; l--)
          if (out_result[l*32 +: 32] !== exp_q[0].res[l*32 +: 32]) bad = l;
        n_checks++;
        if (bad >= 0) begin
          n_err++;
          $display("FAIL result lane %0d: got %h expected %h", bad,
                   out_result[bad*32 +: 32], exp_q[0].res[bad*32 +: 32]);
        end
        chk("out_warp", 32'(out_warp), 32'(exp_q[0].warp));
        chk("out_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
        chk("in_ready_while_held", 32'(in_ready), 32'd0);
      end
    end
  end

  always @(posedge clk)
    if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());

  task automatic accept(input bit push);
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (push) exp_q.push_back(model());
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_out(input string name);
    int n, lat;
    n = 0;
    lat = exp_latency();
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: out_valid low after 400 cycles, expected latency %0d", name, lat);
    end else begin
      chk({name, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(lat));
    end
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("released_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic issue(input logic [7:0] op, input logic [4:0] warp, input logic [31:0] imm,
                       input string name);
    in_op = op; in_warp = warp; in_imm = imm;
    accept(1'b1);
    wait_out(name);
  endtask

  task automatic pattern(input logic [31:0] k, input logic [31:0] imm);
    for (int l = 0; l < WS; l++) begin
      s_rs1[l] = 32'(l) * 32'h9E37_79B9 + k;
      s_rs2[l] = (l % 3 == 0) ? s_rs1[l] - imm : 32'(l) * 32'h0101_0307 - k;
      s_rs3[l] = 32'(l) * 32'h0BAD_F00D ^ k;
    end
    in_pred = 32'h5A3C_96E1 ^ k;
  endtask

  logic [7:0] ops [14];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ops = '{SUB, MUL, IMAD, AND_, OR_, XOR_, SLT, SEQ, SLE, IMIN, IMAX, MOV, SELP, TID};
    pattern(32'd1, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_warp", 32'(out_warp), 32'd0);
    chk("rst_out_result", 32'(out_result != '0), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD: result[l] = l + 100 + 5
    for (int l = 0; l < WS; l++) begin s_rs1[l] = 32'(l); s_rs2[l] = 32'd100; end
    in_mask = '1;
    issue(ADD, 5'd7, 32'd5, "add");
    chk("add_lane0", lane(0), 32'd105);
    chk("add_lane31", lane(31), 32'd136);
    chk("add_warp", 32'(out_warp), 32'd7);
    release_out(0);

    // Single-lane divide corner cases
    pattern(32'h55, 32'd0);
    in_mask = 32'h1;
    s_rs1[0] = 32'hFFFF_FFF9; s_rs2[0] = 32'd2;
    issue(IDIV, 5'd1, 32'd0, "div_m7_2");
    chk("div_m7_2_q", lane(0), 32'hFFFF_FFFD);
    chk("div_m7_2_lane1", lane(1), 32'd0);
    release_out(0);
    issue(IREM, 5'd2, 32'd0, "rem_m7_2");
    chk("rem_m7_2_r", lane(0), 32'hFFFF_FFFF);
    release_out(0);
    s_rs2[0] = 32'd0;
    issue(IDIV, 5'd3, 32'd0, "div_by0");
    chk("div_by0_q", lane(0), 32'hFFFF_FFFF);
    release_out(0);
    issue(IREM, 5'd4, 32'd0, "rem_by0");
    chk("rem_by0_r", lane(0), 32'hFFFF_FFF9);
    release_out(0);
    s_rs1[0] = 32'h8000_0000; s_rs2[0] = 32'hFFFF_FFFF;
    issue(IDIV, 5'd5, 32'd0, "div_ovf");
    chk("div_ovf_q", lane(0), 32'h8000_0000);
    release_out(0);
    issue(IREM, 5'd6, 32'd0, "rem_ovf");
    chk("rem_ovf_r", lane(0), 32'd0);
    release_out(0);

    // Partial mask: only chunk 0 divides, the others are skipped
    pattern(32'h1234, 32'd0);
    for (int l = 0; l < 8; l++) begin
      s_rs1[l] = 32'(100 * l - 350);
      s_rs2[l] = 32'(l - 3);
    end
    in_mask = 32'h0000_00FF;
    issue(IDIV, 5'd8, 32'd0, "div_skip");
    chk("div_skip_lane8", lane(8), 32'd0);
    release_out(0);

    // Full-warp divide and remainder with mixed signs, zero and overflow lanes
    for (int l = 0; l < WS; l++) begin
      s_rs1[l] = (l % 2 == 0) ? 32'(l) * 32'h0765_4321 : -(32'(l) * 32'h0012_3457);
      s_rs2[l] = 32'(l % 7 - 3);
    end
    s_rs1[5] = 32'h8000_0000; s_rs2[5] = 32'hFFFF_FFFF;
    in_mask = 32'hFFFF_FFFF;
    issue(IDIV, 5'd9, 32'd0, "div_full");
    release_out(0);
    in_mask = 32'hF7FF_EFFF;
    issue(IREM, 5'd10, 32'd3, "rem_full");
    release_out(0);

    // Shifts, including amounts of 32 and above
    in_mask = '1;
    for (int l = 0; l < WS; l++) begin
      s_rs1[l] = 32'h8000_0000 ^ (32'(l) * 32'h1111_1111);
      s_rs2[l] = 32'(l * 2);
    end
    s_rs2[0] = 32'd40;
    issue(SHA, 5'd11, 32'd0, "sha");
    chk("sha_lane0", lane(0), 32'hFFFF_FFFF);
    release_out(0);
    issue(SHL, 5'd12, 32'd0, "shl");
    chk("shl_lane0", lane(0), 32'd0);
    release_out(0);
    s_rs1[0] = 32'h0000_00F0; s_rs2[0] = 32'd1;
    issue(SHR, 5'd13, 32'd3, "shr");
    chk("shr_lane0", lane(0), 32'h0000_000F);
    release_out(0);

    // Remaining operations on a patterned, partially masked warp
    for (int i = 0; i < 14; i++) begin
      pattern(32'(i) * 32'h3F1, 32'h0000_0F0C);
      in_mask = 32'hA5A5_F00F;
      issue(ops[i], 5'(i + 14), 32'h0000_0F0C, $sformatf("op%02h", ops[i]));
      release_out(0);
    end

    // Backpressure: held result stays stable, a pending offer waits for release
    pattern(32'd77, 32'd11);
    in_mask = '1;
    issue(MUL, 5'd9, 32'd11, "bp");
    in_op = SUB; in_warp = 5'd10;
    in_valid = 1'b1;
    repeat (10) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    accept(1'b1);
    wait_out("bp_next");
    chk("bp_next_warp", 32'(out_warp), 32'd10);
    release_out(0);

    // Reset in the middle of a divide discards it
    pattern(32'd99, 32'd0);
    in_op = IDIV; in_warp = 5'd20; in_imm = 32'd0;
    accept(1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_div_valid", 32'(out_valid), 32'd0);
    chk("rst_div_ready", 32'(in_ready), 32'd1);
    for (int l = 0; l < WS; l++) begin s_rs1[l] = 32'(l); s_rs2[l] = 32'd100; end
    issue(ADD, 5'd21, 32'd5, "add_after_rst");
    chk("add_after_rst_lane4", lane(4), 32'd109);
    release_out(0);

    // Unsupported opcode, then a legal one clears the flag
    pattern(32'd5, 32'd0);
    issue(8'hFF, 5'd22, 32'd0, "illegal");
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_lane0", lane(0), 32'd0);
    release_out(0);
    issue(XOR_, 5'd23, 32'd0, "after_illegal");
    chk("after_illegal_flag", 32'(out_illegal), 32'd0);
    release_out(0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/int_alu_pipe.md
Name: int_alu_pipe

Overview:
- Sequential, lane-chunked successor to the combinational warp integer ALU in the SIMT core's execute stage.
- Accepts one warp instruction through a valid/ready handshake and processes it in chunks of LANES lanes per beat.
- Provides iterative radix-2 signed divide/remainder and per-lane active masking.
- Holds the full warp result until the writeback stage accepts it.

Parameters:
- WARP_SIZE, 32, lanes per warp; must be a multiple of LANES.
- LANES, 8, lanes computed per beat; BEATS = WARP_SIZE/LANES.
- DIV_ITERS, 32, cycles per divide chunk; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept an instruction.
- in_op  in  8  opcode, simt_pkg opcode_e encoding.
- in_warp  in  5  warp id, carried through to the output.
- in_imm  in  32  immediate.
- in_rs1, in_rs2, in_rs3  in  WARP_SIZE*32 each  per-lane operands.
- in_pred  in  WARP_SIZE  per-lane select predicate (SELP).
- in_mask  in  WARP_SIZE  active-lane mask.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts the result.
- out_warp  out  5  warp id of the held result.
- out_result  out  WARP_SIZE*32  per-lane result.
- out_illegal  out  1  opcode was not supported.

Behaviour:
- Reset: in_ready=1, out_valid=0, out_warp=0, out_result=0, out_illegal=0, FSM to IDLE. Reset mid-operation discards the instruction and any pending divide with no output.
- FSM states IDLE, EXEC, DIV, DONE.
- IDLE: in_ready=1. On in_valid, capture op, warp, imm, rs1/2/3, pred, mask; set chunk=0; clear the result register. Go to DIV for IDIV/IREM, otherwise EXEC. No output occurs in the capture cycle.
- Any FSM state other than IDLE: in_ready=0.
- EXEC: computes lanes chunk*LANES .. chunk*LANES+LANES-1 each cycle. Last chunk goes to DONE. Accept-to-out_valid latency is BEATS+1 cycles (5 with defaults).
- DIV: each chunk runs a restoring divide on |rs1| and |rs2+imm| for DIV_ITERS cycles, then sign fix on write.
  - Chunk with all mask bits 0: skipped in 1 cycle.
  - Worst-case latency: BEATS*32+1.
- DONE: out_valid=1. Hold outputs stable until out_valid&&out_ready, then go to IDLE with in_ready=1 the next cycle. There is no same-cycle accept/release.
- Inactive lane (mask=0): result 0.
- Operations; B = rs2+imm, wrap mod 2^32:
  - ADD: rs1+rs2+imm.
  - SUB: rs1-rs2-imm.
  - MUL: rs1*B, low 32 bits.
  - IMAD: rs1*rs2+rs3, low 32 bits.
  - AND/OR/XOR: rs1 op (rs2|imm).
  - SHL/SHR/SHA: shift by B. If B≥32: SHL/SHR give 0, SHA gives 32 copies of the sign bit.
  - SLT: unsigned rs1<B.
  - SEQ: rs1==B.
  - SLE: signed rs1≤B.
  - IMIN/IMAX: signed, result is rs1 or B.
  - MOV: rs1|imm.
  - SELP: pred ? rs1 : rs2.
  - TID: lane index.
  - Comparison results are 0 or 1.
- Divide rules, with the quotient truncated toward zero:
  - B==0: quotient 0xFFFFFFFF, remainder rs1.
  - rs1==0x80000000 and B==0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Remainder takes the sign of rs1.
- Any other opcode: result all zero, out_illegal=1, goes through EXEC with normal latency.
- out_illegal is cleared on the next capture.

Test Plan:
- ADD: rs1[l]=l, rs2[l]=100, imm=5, mask all 1 -> out_valid 5 cycles after accept; result[l]=105+l; out_warp=in_warp.
- IDIV/IREM, single lane: rs1=-7, rs2=2, imm=0 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Same rs1 with rs2=0 -> quotient 0xFFFFFFFF, remainder -7. rs1=0x80000000, rs2=-1 -> quotient 0x80000000.
- IDIV skip: mask=0x000000FF with defaults -> latency 32+3+1=36 cycles; lanes 8..31 are 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result and warp stable, in_ready=0 throughout; a new in_valid is not accepted until the cycle after release.
- Shifts: SHA rs1=0x80000000, rs2=40 -> 0xFFFFFFFF; SHL same operands -> 0; SHR rs1=0xF0, B=4 -> 0x0F.
- Reset mid-DIV: rst asserted at cycle 10 of the divide -> next cycle out_valid=0, in_ready=1; a following ADD completes correctly. Unknown op 0xFF -> out_illegal=1, result 0.
